// File: rtl/as5600_i2c_target_if.sv
// Pad-side signals of the AS5600 I2C target emulator, bundled for the top-level port.
interface as5600_i2c_target_if;
  logic        scl_i;
  logic        sda_i;
  logic        sda_oe_o;
  logic [11:0] angle_i;
  logic        busy_o;
  logic        rd_done_o;

  modport slave  (input scl_i, sda_i, angle_i, output sda_oe_o, busy_o, rd_done_o);
  modport master (output scl_i, sda_i, angle_i, input sda_oe_o, busy_o, rd_done_o);
endinterface

// File: rtl/as5600_i2c_target.sv
// AS5600-style I2C target: pointer register, coherent angle snapshot reads.
// Optional ZPOS offset registers are enabled by defining AS5600_TGT_ZPOS_EN.
module as5600_i2c_target #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h36,
  parameter int         SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst_n,
  as5600_i2c_target_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, ADDR = 4'd1, ADDR_ACK = 4'd2, PTR = 4'd3, PTR_ACK = 4'd4,
    WDATA = 4'd5, WDATA_ACK = 4'd6, RDATA = 4'd7, RDATA_ACK = 4'd8, IGNORE = 4'd9
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d, tx_q, tx_d, ptr_q, ptr_d;
  logic [11:0]            snap_q, snap_d, zpos_s;
  logic                   rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d, rd_done_q, rd_done_d;
  logic                   scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  logic                   byte_done_s, addr_match_s;
  logic [7:0]             ptr_inc_s, first_byte_s, next_byte_s;

  function automatic logic [7:0] reg_read(input logic [7:0] addr, input logic [11:0] raw,
                                          input logic [11:0] zpos);
    logic [11:0] adj;
    adj = raw - zpos;
    case (addr)
      8'h01:   reg_read = {4'h0, zpos[11:8]};
      8'h02:   reg_read = zpos[7:0];
      8'h0C:   reg_read = {4'h0, raw[11:8]};
      8'h0D:   reg_read = raw[7:0];
      8'h0E:   reg_read = {4'h0, adj[11:8]};
      8'h0F:   reg_read = adj[7:0];
      default: reg_read = 8'h00;
    endcase
  endfunction

  assign scl_s        = scl_sync_q[SYNC_STAGES-1];
  assign sda_s        = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_s   = scl_s & ~scl_prev_q;
  assign scl_fall_s   = ~scl_s & scl_prev_q;
  assign start_s      = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_s       = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign byte_done_s  = (bit_cnt_q == 4'd8);
  assign addr_match_s = (shift_q[7:1] == SLAVE_ADDR);
  assign ptr_inc_s    = ptr_q + 8'd1;
  assign first_byte_s = reg_read(ptr_q, snap_q, zpos_s);
  assign next_byte_s  = reg_read(ptr_inc_s, snap_q, zpos_s);

  // Pad synchronisers plus one history stage for START/STOP and SCL edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; bus conditions win over byte progress, which advances on SCL fall
  always_comb begin
    state_d = state_q;
    if (start_s) begin
      state_d = ADDR;
    end else if (stop_s) begin
      state_d = IDLE;
    end else if (scl_fall_s) begin
      case (state_q)
        ADDR:      state_d = byte_done_s ? (addr_match_s ? ADDR_ACK : IGNORE) : ADDR;
        ADDR_ACK:  state_d = rw_q ? RDATA : PTR;
        PTR:       state_d = byte_done_s ? PTR_ACK : PTR;
        PTR_ACK:   state_d = WDATA;
        WDATA:     state_d = byte_done_s ? WDATA_ACK : WDATA;
        WDATA_ACK: state_d = WDATA;
        RDATA:     state_d = byte_done_s ? RDATA_ACK : RDATA;
        RDATA_ACK: state_d = shift_q[0] ? IGNORE : RDATA;
        default:   state_d = state_q;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Datapath and output next values; SDA drive only changes just after an SCL fall
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    snap_d    = snap_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    rd_done_d = 1'b0;
    if (start_s) begin
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_s) begin
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (scl_rise_s) begin
      shift_d   = {shift_q[6:0], sda_s};
      bit_cnt_d = byte_done_s ? bit_cnt_q : bit_cnt_q + 4'd1;
    end else if (scl_fall_s) begin
      case (state_q)
        ADDR: begin
          if (byte_done_s) begin
            sda_oe_d = addr_match_s;
            rw_d     = shift_q[0];
            busy_d   = busy_q | addr_match_s;
            snap_d   = (addr_match_s & shift_q[0]) ? bus.angle_i : snap_q;
          end else begin
            sda_oe_d = 1'b0;
          end
        end
        ADDR_ACK: begin
          bit_cnt_d = 4'd0;
          tx_d      = first_byte_s;
          sda_oe_d  = rw_q & ~first_byte_s[7];
        end
        PTR: begin
          if (byte_done_s) begin
            ptr_d    = shift_q;
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
          end
        end
        WDATA: begin
          if (byte_done_s) begin
            ptr_d    = ptr_inc_s;
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
          end
        end
        PTR_ACK, WDATA_ACK: begin
          bit_cnt_d = 4'd0;
          sda_oe_d  = 1'b0;
        end
        RDATA: begin
          if (byte_done_s) begin
            sda_oe_d = 1'b0;
          end else begin
            tx_d     = {tx_q[6:0], 1'b1};
            sda_oe_d = ~tx_q[6];
          end
        end
        RDATA_ACK: begin
          bit_cnt_d = 4'd0;
          ptr_d     = ptr_inc_s;
          tx_d      = next_byte_s;
          sda_oe_d  = ~shift_q[0] & ~next_byte_s[7];
          rd_done_d = shift_q[0];
        end
        default: sda_oe_d = 1'b0;
      endcase
    end else begin
      sda_oe_d = sda_oe_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      tx_q      <= 8'h00;
      ptr_q     <= 8'h00;
      snap_q    <= 12'h000;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      snap_q    <= snap_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      rd_done_q <= rd_done_d;
    end
  end

`ifdef AS5600_TGT_ZPOS_EN
  logic [11:0] zpos_q, zpos_d;

  // ZPOS is written when a data byte completes at pointer 0x01 or 0x02
  always_comb begin
    zpos_d = zpos_q;
    if (scl_fall_s && !start_s && !stop_s && state_q == WDATA && byte_done_s) begin
      case (ptr_q)
        8'h01:   zpos_d = {shift_q[3:0], zpos_q[7:0]};
        8'h02:   zpos_d = {zpos_q[11:8], shift_q};
        default: zpos_d = zpos_q;
      endcase
    end else begin
      zpos_d = zpos_q;
    end
  end

  // ZPOS register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zpos_q <= 12'h000;
    else        zpos_q <= zpos_d;
  end

  assign zpos_s = zpos_q;
`else
  assign zpos_s = 12'h000;
`endif

  assign bus.sda_oe_o  = sda_oe_q;
  assign bus.busy_o    = busy_q;
  assign bus.rd_done_o = rd_done_q;
endmodule

// File: tb/tb_as5600_i2c_target.sv
// Directed bench for as5600_i2c_target: bit-banged I2C master, read-byte scoreboard.
module tb_as5600_i2c_target;
  localparam int Q = 4;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda_low = 1'b0;
  logic [11:0] angle = 12'h000;
  int          total = 0;
  int          bad = 0;
  int          rd_cnt = 0, busy_cnt = 0, oe_cnt = 0, hi_drive_cnt = 0;
  logic        oe_prev = 1'b0;
  logic [7:0]  exp_q[$];

  as5600_i2c_target_if bus();
  wire sda_line = ~(m_sda_low | bus.sda_oe_o);
  assign bus.scl_i   = m_scl;
  assign bus.sda_i   = sda_line;
  assign bus.angle_i = angle;

  as5600_i2c_target #(.SLAVE_ADDR(7'h36), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rd_done_o) rd_cnt <= rd_cnt + 1;
    if (bus.busy_o) busy_cnt <= busy_cnt + 1;
    if (bus.sda_oe_o) oe_cnt <= oe_cnt + 1;
    if (bus.sda_oe_o && !oe_prev && m_scl) hi_drive_cnt <= hi_drive_cnt + 1;
    oe_prev <= bus.sda_oe_o;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_q();
    m_scl = 1'b1;     wait_q(); wait_q();
    m_sda_low = 1'b1; wait_q();
    m_scl = 1'b0;     wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_q();
    m_scl = 1'b1;     wait_q();
    m_sda_low = 1'b0; wait_q(); wait_q();
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; wait_q();
    m_scl = 1'b1;   wait_q(); wait_q();
    m_scl = 1'b0;   wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; wait_q();
    m_scl = 1'b1;     wait_q();
    b = sda_line;     wait_q();
    m_scl = 1'b0;     wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    check(tag, {15'h0, ~a}, {15'h0, exp_ack});
  endtask

  task automatic read_data(output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
  endtask

  // Read one byte, respond ACK/NACK, compare against the scoreboard head
  task automatic rd_expect(input logic [7:0] exp, input logic ack, input string tag);
    logic [7:0] d;
    exp_q.push_back(exp);
    read_data(d);
    write_bit(~ack);
    check(tag, {8'h00, d}, {8'h00, exp_q.pop_front()});
  endtask

  task automatic set_ptr(input logic [7:0] p);
    i2c_start();
    write_byte(8'h6C, 1'b1, "waddr_ack");
    write_byte(p, 1'b1, "ptr_ack");
  endtask

  task automatic read_addr();
    i2c_start();
    write_byte(8'h6D, 1'b1, "raddr_ack");
  endtask

  initial begin
    logic [7:0] d;
    int rd0, busy0, oe0;
    bit seen;

    repeat (4) @(posedge clk);
    #1;
    check("rst_sda_oe", {15'h0, bus.sda_oe_o}, 16'h0000);
    check("rst_busy", {15'h0, bus.busy_o}, 16'h0000);
    check("rst_rd_done", {15'h0, bus.rd_done_o}, 16'h0000);
    rst_n = 1'b1;
    wait_q();

    // Pointer write, repeated START, two-byte read of the adjusted angle
    angle = 12'hABC;
    rd0 = rd_cnt;
    set_ptr(8'h0E);
    read_addr();
    rd_expect(8'h0A, 1'b1, "rd_0E_hi");
    rd_expect(8'hBC, 1'b0, "rd_0F_lo");
    check("busy_in_xfer", {15'h0, bus.busy_o}, 16'h0001);
    i2c_stop();
    check("busy_after_stop", {15'h0, bus.busy_o}, 16'h0000);
    check("rd_done_once", 16'(rd_cnt - rd0), 16'h0001);

    // Foreign address must be ignored entirely
    busy0 = busy_cnt;
    oe0 = oe_cnt;
    i2c_start();
    write_byte(8'hA0, 1'b0, "foreign_addr_nack");
    write_byte(8'h0C, 1'b0, "foreign_data_nack");
    i2c_stop();
    check("foreign_no_drive", 16'(oe_cnt - oe0), 16'h0000);
    check("foreign_no_busy", 16'(busy_cnt - busy0), 16'h0000);

    // Angle moves between the two bytes; the snapshot keeps the read coherent
    angle = 12'h100;
    set_ptr(8'h0E);
    read_addr();
    exp_q.push_back(8'h01);
    read_data(d);
    angle = 12'hFFF;
    write_bit(1'b0);
    check("snap_byte1", {8'h00, d}, {8'h00, exp_q.pop_front()});
    rd_expect(8'h00, 1'b0, "snap_byte2");
    i2c_stop();

    // Pointer wrap and retention across transfers
    angle = 12'h1E7;
    set_ptr(8'hFF);
    i2c_stop();
    read_addr();
    rd_expect(8'h00, 1'b1, "wrap_rd_FF");
    rd_expect(8'h00, 1'b0, "wrap_rd_00");
    i2c_stop();
    read_addr();
    rd_expect(8'h00, 1'b0, "wrap_next_01");
    i2c_stop();
    set_ptr(8'h0C);
    read_addr();
    rd_expect(8'h01, 1'b0, "retain_rd_0C");
    i2c_stop();
    read_addr();
    rd_expect(8'hE7, 1'b0, "retain_rd_0D");
    i2c_stop();

    // ZPOS write and offset readback
    angle = 12'h008;
    set_ptr(8'h01);
    write_byte(8'h00, 1'b1, "zpos_hi_ack");
    write_byte(8'h10, 1'b1, "zpos_lo_ack");
    i2c_stop();
    set_ptr(8'h01);
    read_addr();
`ifdef AS5600_TGT_ZPOS_EN
    rd_expect(8'h00, 1'b1, "zpos_rd_01");
    rd_expect(8'h10, 1'b0, "zpos_rd_02");
    i2c_stop();
    set_ptr(8'h0E);
    read_addr();
    rd_expect(8'h0F, 1'b1, "zpos_rd_0E");
    rd_expect(8'hF8, 1'b0, "zpos_rd_0F");
`else
    rd_expect(8'h00, 1'b1, "zpos_rd_01");
    rd_expect(8'h00, 1'b0, "zpos_rd_02");
    i2c_stop();
    set_ptr(8'h0E);
    read_addr();
    rd_expect(8'h00, 1'b1, "zpos_rd_0E");
    rd_expect(8'h08, 1'b0, "zpos_rd_0F");
`endif
    i2c_stop();
    set_ptr(8'h0C);
    read_addr();
    rd_expect(8'h00, 1'b1, "raw_rd_0C");
    rd_expect(8'h08, 1'b0, "raw_rd_0D");
    i2c_stop();

    // Reset while the target is pulling SDA low for a read data bit
    angle = 12'h000;
    set_ptr(8'h0D);
    read_addr();
    for (int i = 0; i < 3; i++) read_bit(d[0]);
    seen = 1'b0;
    for (int i = 0; i < 4 * Q && !seen; i++) begin
      if (bus.sda_oe_o === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("mid_read_drive_seen", {15'h0, seen}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("rst_async_release", {15'h0, bus.sda_oe_o}, 16'h0000);
    check("rst_async_busy", {15'h0, bus.busy_o}, 16'h0000);
    m_sda_low = 1'b0;
    m_scl = 1'b1;
    wait_q();
    rst_n = 1'b1;
    wait_q();
    angle = 12'h5A3;
    set_ptr(8'h0C);
    read_addr();
    rd_expect(8'h05, 1'b1, "post_rst_0C");
    rd_expect(8'hA3, 1'b0, "post_rst_0D");
    i2c_stop();

    check("no_drive_while_scl_high", 16'(hi_drive_cnt), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
